spi_slave_shifter: RTL and testbench
====================================

# spi_slave_shifter

SPI responder datapath: the far end of the team's SPI master shift register. It oversamples the external `sclk`, `ss` and `mosi` with `pclk`, deserialises `mosi` into bytes, and serialises a host-supplied byte onto `miso` in any of the four CPOL/CPHA modes, LSB- or MSB-first. It sits between the SPI pads and the peripheral's register or FIFO side, and uses a one-byte transmit holding buffer with a valid/ready handshake.

## Interface
- `SYNC_STAGES`, default 2, number of synchroniser flops on `sclk`, `ss` and `mosi` (≥2).
- `pclk` in 1: system clock, all logic on its rising edge.
- `preset` in 1: synchronous active-high reset.
- `cpol` in 1: SCLK idle level.
- `cpha` in 1: 0 = sample on leading edge, 1 = sample on trailing edge.
- `lsbfe` in 1: 1 = LSB first.
- `sclk` in 1: SPI clock from master (asynchronous).
- `ss` in 1: slave select, active-low (asynchronous).
- `mosi` in 1: serial data in (asynchronous).
- `miso` out 1: serial data out, registered.
- `miso_oe` out 1: pad output enable, = synchronised `~ss`.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: `tx_data` valid.
- `tx_ready` out 1: holding buffer empty.
- `rx_data` out 8: last complete received byte.
- `rx_valid` out 1: one-cycle strobe, `rx_data` updated.
- `tx_underrun` out 1: one-cycle strobe, a byte load found the buffer empty.
- `busy` out 1: frame in progress.

## Operation
- States:
  - IDLE → ACTIVE on a synchronised `ss` falling edge. On entry, latch `cpol`, `cpha` and `lsbfe` (static during the frame) and clear `rx_cnt`.
  - ACTIVE → IDLE whenever synchronised `ss` is high.
- Edges:
  - Leading edge = synchronised `sclk` leaving `cpol`; trailing edge = returning to it.
  - Sample edge = leading if `cpha`=0, trailing if `cpha`=1; shift edge = the other one.
  - `sclk` edges are ignored in IDLE.
- Receive:
  - On each sample edge, shift the synchronised `mosi` into `rx_sr`. With `lsbfe`=1 it enters at bit 7 and shifts right; with `lsbfe`=0 it enters at bit 0 and shifts left.
  - `rx_cnt` (3 bits) increments and wraps 7→0.
  - On the sample with `rx_cnt`=7, the assembled byte goes to `rx_data` and `rx_valid` pulses. There is no backpressure; `rx_data` is overwritten on the next byte.
- Transmit load event:
  - `cpha`=0: at IDLE→ACTIVE, and at each shift edge with `rx_cnt`=0.
  - `cpha`=1: at each shift edge with `rx_cnt`=0.
  - Load copies the holding buffer into `tx_sr`, marks the buffer empty, and drives the first bit (bit 0 if `lsbfe`, else bit 7) onto `miso`.
  - If the buffer is empty at load, load 0x00 and pulse `tx_underrun`.
- Transmit, other shift edges: shift `tx_sr` and drive the next bit.
- Holding buffer:
  - `tx_ready` = buffer empty. A write occurs when `tx_valid`&`tx_ready`.
  - Write and load in the same cycle: the write is not forwarded. The load sees an empty buffer (underrun, 0x00), and the written byte stays buffered for the next load.
- `ss` deasserted mid-byte: the partial byte is discarded with no `rx_valid`. `rx_cnt` and `tx_sr` are cleared and `miso`=0. The holding buffer is kept.
- `busy` = state is ACTIVE.

## Timing
- Reset:
  - `miso`, `miso_oe`, `rx_data`, `rx_valid`, `tx_underrun` and `busy` = 0; `tx_ready` = 1.
  - `ss` synchroniser resets to 1; `sclk` synchroniser resets to 0.
  - State goes to IDLE.
  - If `ss` is already low at reset release, the block waits for `ss` to go high and then fall again.
- Latency from the first `pclk` edge that captures a new pin level:
  - Internal edge detection: `SYNC_STAGES` cycles.
  - `miso`, `rx_data`/`rx_valid`, `tx_underrun` and `busy` update one cycle after detection.
- Master constraints:
  - `sclk` high and low phases ≥ `SYNC_STAGES`+2 `pclk` periods.
  - `ss` low ≥ `SYNC_STAGES`+2 `pclk` periods before the first `sclk` edge.
- Strobes (`rx_valid`, `tx_underrun`) are exactly one cycle wide.

## Test plan
- Mode 0, `lsbfe`=0, buffer preloaded with 0xA5, master sends 0x3C -> `miso` carries 1,0,1,0,0,1,0,1 on successive rising edges; `rx_data`=0x3C with one `rx_valid` pulse; `tx_ready` rises at `ss` fall.
- Mode 3, `lsbfe`=1, two back-to-back bytes 0x81 then 0x7E with buffer 0x0F, refilled with 0xF0 mid-byte-1 -> two `rx_valid` pulses (0x81, 0x7E); `miso` streams 0x0F then 0xF0 LSB-first; no underrun.
- Modes 1 and 2, each with 0x96 -> correct capture edge; `rx_data`=0x96.
- Buffer empty at load -> `miso`=0 for all 8 bits; single `tx_underrun` pulse; a write in the load cycle stays buffered and is sent as the next byte.
- `ss` raised after 5 bits -> no `rx_valid`; `busy`=0; `miso`=`miso_oe`=0; the next frame receives 0x55 correctly.
- `preset` pulsed mid-frame with `ss` held low -> all outputs at reset values; no activity until `ss` goes high and falls again.

Source files
------------

// File: rtl/spi_slave_shifter.sv
// SPI responder datapath: synchronises sclk/ss/mosi into pclk, deserialises mosi
// and serialises a one-byte holding buffer onto miso in all four CPOL/CPHA modes.
module spi_slave_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       lsbfe,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       busy
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]             state;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync, fill;
  logic                   sclk_s, ss_s, mosi_s, filled;
  logic                   sclk_prev, ss_hi_seen;
  logic                   cpol_l, cpha_l, lsbfe_l;
  logic [2:0]             rx_cnt;
  logic [7:0]             rx_sr, tx_sr, tx_buf;
  logic                   buf_full;

  logic       sclk_edge, lead_ev, trail_ev, in_frame;
  logic       sample_ev, shift_ev, ss_fall, load_ev, load_lsb, tx_write;
  logic [7:0] load_byte, rx_next;

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign filled   = fill[SYNC_STAGES-1];
  assign busy     = (state == ACTIVE);
  assign tx_ready = ~buf_full;

  always_ff @(posedge pclk) begin
    if (preset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      fill      <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // ss_hi_seen only counts highs that came from the pin, not the synchroniser's
  // reset fill, so ss held low through reset cannot fake a falling edge.
  always_comb begin
    sclk_edge = sclk_s ^ sclk_prev;
    lead_ev   = sclk_edge & (sclk_s != cpol_l);
    trail_ev  = sclk_edge & (sclk_s == cpol_l);
    in_frame  = (state == ACTIVE) & ~ss_s;
    sample_ev = in_frame & (cpha_l ? trail_ev : lead_ev);
    shift_ev  = in_frame & (cpha_l ? lead_ev : trail_ev);
    ss_fall   = (state == IDLE) & ss_hi_seen & filled & ~ss_s;
    load_ev   = (ss_fall & ~cpha) | (shift_ev & (rx_cnt == 3'd0));
    load_lsb  = ss_fall ? lsbfe : lsbfe_l;
    load_byte = buf_full ? tx_buf : 8'h00;
    rx_next   = lsbfe_l ? {mosi_s, rx_sr[7:1]} : {rx_sr[6:0], mosi_s};
    tx_write  = tx_valid & ~buf_full;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= IDLE;
      sclk_prev   <= 1'b0;
      ss_hi_seen  <= 1'b0;
      cpol_l      <= 1'b0;
      cpha_l      <= 1'b0;
      lsbfe_l     <= 1'b0;
      rx_cnt      <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      tx_buf      <= '0;
      buf_full    <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      sclk_prev   <= sclk_s;
      ss_hi_seen  <= filled & ss_s;
      miso_oe     <= ~ss_s;

      // A write is only accepted while empty, so it never collides with the
      // load's clear; a same-cycle load still sees the pre-write (empty) buffer.
      if (tx_write) begin
        tx_buf   <= tx_data;
        buf_full <= 1'b1;
      end else if (load_ev) begin
        buf_full <= 1'b0;
      end

      if (load_ev) begin
        tx_sr       <= load_byte;
        miso        <= load_lsb ? load_byte[0] : load_byte[7];
        tx_underrun <= ~buf_full;
      end else if (shift_ev) begin
        tx_sr <= lsbfe_l ? (tx_sr >> 1) : (tx_sr << 1);
        miso  <= lsbfe_l ? tx_sr[1] : tx_sr[6];
      end

      case (state)
        IDLE: begin
          if (ss_fall) begin
            state   <= ACTIVE;
            cpol_l  <= cpol;
            cpha_l  <= cpha;
            lsbfe_l <= lsbfe;
            rx_cnt  <= '0;
          end
        end
        default: begin
          if (ss_s) begin
            state  <= IDLE;
            rx_cnt <= '0;
            rx_sr  <= '0;
            tx_sr  <= '0;
            miso   <= 1'b0;
          end else if (sample_ev) begin
            rx_sr  <= rx_next;
            rx_cnt <= rx_cnt + 3'd1;
            if (rx_cnt == 3'd7) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter: a behavioural SPI master drives frames in
// each mode and per-scenario tasks compare received and returned bytes.
module tb_spi_slave_shifter;

  localparam int H = 8;

  logic       pclk, preset, cpol, cpha, lsbfe, sclk, ss, mosi;
  logic       miso, miso_oe, tx_valid, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] tx_data, rx_data;

  int         vectors;
  int         miscompares;
  logic [7:0] rx_q[$];
  int         und_cnt;
  int         busy_cnt;

  spi_slave_shifter #(.SYNC_STAGES(2)) dut (
    .pclk(pclk), .preset(preset), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
    .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (tx_underrun) und_cnt++;
    if (busy) busy_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ord(input logic [7:0] b, input logic lsb);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = lsb ? b[i] : b[7-i];
    return r;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic preload(input logic [7:0] d);
    int n;
    @(negedge pclk);
    tx_data  = d;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 500) begin
      @(negedge pclk);
      n++;
    end
    if (!tx_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL preload_timeout: tx_ready=%b required 1", tx_ready);
    end
    @(negedge pclk);
    tx_valid = 1'b0;
  endtask

  task automatic set_mode(input logic c_pol, input logic c_pha, input logic lsb);
    cpol  = c_pol;
    cpha  = c_pha;
    lsbfe = lsb;
    sclk  = c_pol;
    mosi  = 1'b0;
    wait_cyc(8);
  endtask

  task automatic ss_fall(input logic first);
    mosi = first;
    ss   = 1'b0;
    wait_cyc(H);
  endtask

  task automatic ss_rise();
    ss = 1'b1;
    wait_cyc(8);
  endtask

  // Master side: obits/ibits are in wire order (index 0 = first bit on the line).
  task automatic clock_bits(input int nbits, input logic [15:0] obits, output logic [15:0] ibits);
    ibits = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        ibits[i] = miso;
        sclk = ~cpol;
        wait_cyc(H);
        sclk = cpol;
        if (i + 1 < nbits) mosi = obits[i+1];
        wait_cyc(H);
      end else begin
        sclk = ~cpol;
        mosi = obits[i];
        wait_cyc(H);
        ibits[i] = miso;
        sclk = cpol;
        wait_cyc(H);
      end
    end
  endtask

  task automatic run_frame(input logic c_pol, input logic c_pha, input logic lsb,
                           input int nbits, input logic [15:0] obits, output logic [15:0] ibits);
    set_mode(c_pol, c_pha, lsb);
    ss_fall(obits[0]);
    clock_bits(nbits, obits, ibits);
    ss_rise();
  endtask

  task automatic test_reset();
    preset = 1'b1;
    wait_cyc(5);
    vectors++;
    if ({miso, miso_oe, rx_data, rx_valid, tx_underrun, busy, tx_ready} !== 14'b00_00000000_0001) begin
      miscompares++;
      $display("FAIL reset_state: got %b required 00000000000001",
               {miso, miso_oe, rx_data, rx_valid, tx_underrun, busy, tx_ready});
    end
    preset = 1'b0;
    wait_cyc(8);
    vectors++;
    if (busy !== 1'b0 || tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: busy=%b tx_ready=%b required 0 1", busy, tx_ready);
    end
  endtask

  task automatic test_mode0();
    logic [15:0] ib;
    logic [7:0]  got;
    rx_q.delete();
    preload(8'hA5);
    vectors++;
    if (tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL m0_buf_full: tx_ready=%b required 0", tx_ready);
    end
    set_mode(1'b0, 1'b0, 1'b0);
    ss_fall(ord(8'h3C, 1'b0) & 8'h01 ? 1'b1 : 1'b0);
    vectors++;
    if ({tx_ready, busy, miso_oe} !== 3'b111) begin
      miscompares++;
      $display("FAIL m0_after_ss_fall: tx_ready,busy,miso_oe=%b required 111", {tx_ready, busy, miso_oe});
    end
    clock_bits(8, {8'h00, ord(8'h3C, 1'b0)}, ib);
    ss_rise();
    vectors++;
    if (ord(ib[7:0], 1'b0) !== 8'hA5) begin
      miscompares++;
      $display("FAIL m0_miso: got %h required a5", ord(ib[7:0], 1'b0));
    end
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    vectors++;
    if (rx_q.size() != 1 || got !== 8'h3C) begin
      miscompares++;
      $display("FAIL m0_rx: count=%0d data=%h required 1 3c", rx_q.size(), got);
    end
    vectors++;
    if (busy !== 1'b0 || miso_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL m0_end: busy=%b miso_oe=%b required 0 0", busy, miso_oe);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ib;
    logic [7:0]  g0, g1;
    rx_q.delete();
    und_cnt = 0;
    preload(8'h0F);
    fork
      run_frame(1'b1, 1'b1, 1'b1, 16, {ord(8'h7E, 1'b1), ord(8'h81, 1'b1)}, ib);
      begin
        wait_cyc(60);
        preload(8'hF0);
      end
    join
    g0 = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    g1 = (rx_q.size() > 1) ? rx_q[1] : 8'hxx;
    vectors++;
    if (rx_q.size() != 2 || g0 !== 8'h81 || g1 !== 8'h7E) begin
      miscompares++;
      $display("FAIL b2b_rx: count=%0d data=%h,%h required 2 81,7e", rx_q.size(), g0, g1);
    end
    vectors++;
    if (ord(ib[7:0], 1'b1) !== 8'h0F || ord(ib[15:8], 1'b1) !== 8'hF0) begin
      miscompares++;
      $display("FAIL b2b_miso: got %h,%h required 0f,f0", ord(ib[7:0], 1'b1), ord(ib[15:8], 1'b1));
    end
    vectors++;
    if (und_cnt != 0) begin
      miscompares++;
      $display("FAIL b2b_underrun: pulses=%0d required 0", und_cnt);
    end
  endtask

  task automatic test_modes12();
    logic [15:0] ib;
    logic [7:0]  got;
    rx_q.delete();
    preload(8'h5A);
    run_frame(1'b0, 1'b1, 1'b0, 8, {8'h00, ord(8'h96, 1'b0)}, ib);
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    vectors++;
    if (rx_q.size() != 1 || got !== 8'h96) begin
      miscompares++;
      $display("FAIL m1_rx: count=%0d data=%h required 1 96", rx_q.size(), got);
    end
    vectors++;
    if (ord(ib[7:0], 1'b0) !== 8'h5A) begin
      miscompares++;
      $display("FAIL m1_miso: got %h required 5a", ord(ib[7:0], 1'b0));
    end
    rx_q.delete();
    preload(8'h3C);
    run_frame(1'b1, 1'b0, 1'b0, 8, {8'h00, ord(8'h96, 1'b0)}, ib);
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    vectors++;
    if (rx_q.size() != 1 || got !== 8'h96) begin
      miscompares++;
      $display("FAIL m2_rx: count=%0d data=%h required 1 96", rx_q.size(), got);
    end
    vectors++;
    if (ord(ib[7:0], 1'b0) !== 8'h3C) begin
      miscompares++;
      $display("FAIL m2_miso: got %h required 3c", ord(ib[7:0], 1'b0));
    end
  endtask

  task automatic test_underrun();
    logic [15:0] ib;
    logic [7:0]  g0, g1;
    rx_q.delete();
    wait_cyc(4);
    und_cnt = 0;
    vectors++;
    if (tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ur_empty: tx_ready=%b required 1", tx_ready);
    end
    fork
      run_frame(1'b0, 1'b1, 1'b0, 16, {ord(8'h34, 1'b0), ord(8'h12, 1'b0)}, ib);
      begin
        wait (ss == 1'b0);
        wait (sclk == 1'b1);
        @(negedge pclk);
        @(negedge pclk);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        vectors++;
        if (tx_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL ur_write_ready: tx_ready=%b required 1", tx_ready);
        end
        @(negedge pclk);
        tx_valid = 1'b0;
      end
    join
    vectors++;
    if (ord(ib[7:0], 1'b0) !== 8'h00 || ord(ib[15:8], 1'b0) !== 8'hC3) begin
      miscompares++;
      $display("FAIL ur_miso: got %h,%h required 00,c3", ord(ib[7:0], 1'b0), ord(ib[15:8], 1'b0));
    end
    vectors++;
    if (und_cnt != 1) begin
      miscompares++;
      $display("FAIL ur_pulses: pulses=%0d required 1", und_cnt);
    end
    g0 = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    g1 = (rx_q.size() > 1) ? rx_q[1] : 8'hxx;
    vectors++;
    if (rx_q.size() != 2 || g0 !== 8'h12 || g1 !== 8'h34) begin
      miscompares++;
      $display("FAIL ur_rx: count=%0d data=%h,%h required 2 12,34", rx_q.size(), g0, g1);
    end
  endtask

  task automatic test_abort();
    logic [15:0] ib;
    logic [7:0]  got;
    rx_q.delete();
    preload(8'hAA);
    run_frame(1'b0, 1'b0, 1'b0, 5, {8'h00, 8'hFF}, ib);
    vectors++;
    if (rx_q.size() != 0) begin
      miscompares++;
      $display("FAIL abort_rx: count=%0d required 0", rx_q.size());
    end
    vectors++;
    if ({busy, miso, miso_oe} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_outputs: busy,miso,miso_oe=%b required 000", {busy, miso, miso_oe});
    end
    preload(8'hC3);
    run_frame(1'b0, 1'b0, 1'b0, 8, {8'h00, ord(8'h55, 1'b0)}, ib);
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    vectors++;
    if (rx_q.size() != 1 || got !== 8'h55) begin
      miscompares++;
      $display("FAIL abort_next_rx: count=%0d data=%h required 1 55", rx_q.size(), got);
    end
    vectors++;
    if (ord(ib[7:0], 1'b0) !== 8'hC3) begin
      miscompares++;
      $display("FAIL abort_next_miso: got %h required c3", ord(ib[7:0], 1'b0));
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] ib;
    logic [7:0]  got;
    preload(8'h11);
    set_mode(1'b0, 1'b0, 1'b0);
    ss_fall(1'b1);
    clock_bits(3, 16'h00FF, ib);
    preset = 1'b1;
    wait_cyc(3);
    vectors++;
    if ({miso, miso_oe, rx_data, rx_valid, tx_underrun, busy, tx_ready} !== 14'b00_00000000_0001) begin
      miscompares++;
      $display("FAIL midreset_state: got %b required 00000000000001",
               {miso, miso_oe, rx_data, rx_valid, tx_underrun, busy, tx_ready});
    end
    preset = 1'b0;
    wait_cyc(2);
    rx_q.delete();
    busy_cnt = 0;
    clock_bits(8, {8'h00, ord(8'h99, 1'b0)}, ib);
    vectors++;
    if (rx_q.size() != 0 || busy_cnt != 0) begin
      miscompares++;
      $display("FAIL midreset_quiet: rx=%0d busy_cycles=%0d required 0 0", rx_q.size(), busy_cnt);
    end
    ss_rise();
    run_frame(1'b0, 1'b0, 1'b0, 8, {8'h00, ord(8'hE7, 1'b0)}, ib);
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    vectors++;
    if (rx_q.size() != 1 || got !== 8'hE7) begin
      miscompares++;
      $display("FAIL midreset_next_rx: count=%0d data=%h required 1 e7", rx_q.size(), got);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    und_cnt     = 0;
    busy_cnt    = 0;
    preset      = 1'b1;
    cpol        = 1'b0;
    cpha        = 1'b0;
    lsbfe       = 1'b0;
    sclk        = 1'b0;
    ss          = 1'b1;
    mosi        = 1'b0;
    tx_data     = '0;
    tx_valid    = 1'b0;
    test_reset();
    test_mode0();
    test_back_to_back();
    test_modes12();
    test_underrun();
    test_abort();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
